// File: rtl/bound_rr_sched.sv
// Round-robin scheduler sharing one registered clamp/ReLU stage among N_LANE
// accumulator+bias lanes, with a sticky saturation-event counter.
module bound_rr_sched #(
    parameter int N_LANE = 4,
    parameter int D_BW   = 8,
    parameter int AB_BW  = 21,
    parameter int CNT_BW = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_relu_en,
    input  logic                         i_cnt_clr,
    input  logic [N_LANE-1:0]            i_req_valid,
    input  logic [N_LANE*AB_BW-1:0]      i_req_data,
    output logic [N_LANE-1:0]            o_req_ready,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [D_BW-1:0]              o_data,
    output logic [$clog2(N_LANE)-1:0]    o_lane,
    output logic [CNT_BW-1:0]            o_sat_cnt
);

    localparam int LW = $clog2(N_LANE);
    localparam logic signed [AB_BW-1:0] D_MAX = {{(AB_BW-D_BW+1){1'b0}}, {(D_BW-1){1'b1}}};
    localparam logic signed [AB_BW-1:0] D_MIN = {{(AB_BW-D_BW+1){1'b1}}, {(D_BW-1){1'b0}}};

    logic [LW-1:0]           rr_ptr;
    logic [LW-1:0]           grant;
    logic                    any_valid;
    logic                    accept;
    logic                    xfer;
    logic signed [AB_BW-1:0] sel_data;
    logic [D_BW-1:0]         bounded;
    logic                    sat_hit;

    assign accept = ~o_valid | i_ready;
    assign xfer   = any_valid & accept;

    // Cyclic search from rr_ptr; the first valid lane found wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        any_valid = 1'b0;
        grant     = '0;
        for (int unsigned i = 0; i < unsigned'(N_LANE); i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= unsigned'(N_LANE)) idx = idx - unsigned'(N_LANE);
            if (!any_valid && i_req_valid[LW'(idx)]) begin
                any_valid = 1'b1;
                grant     = LW'(idx);
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (rst_n && xfer) o_req_ready[grant] = 1'b1;
    end

    assign sel_data = i_req_data[32'(grant)*AB_BW +: AB_BW];

    // Full-width signed compare; ReLU zeroing takes priority and is not a clamp event.
    always_comb begin
        sat_hit = 1'b0;
        bounded = sel_data[D_BW-1:0];
        if (i_relu_en && sel_data[AB_BW-1]) begin
            bounded = '0;
        end else if (sel_data > D_MAX) begin
            bounded = {1'b0, {(D_BW-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (sel_data < D_MIN) begin
            bounded = {1'b1, {(D_BW-1){1'b0}}};
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_lane  <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            if (any_valid) begin
                o_valid <= 1'b1;
                o_data  <= bounded;
                o_lane  <= grant;
                rr_ptr  <= (grant == LW'(N_LANE-1)) ? '0 : grant + 1'b1;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sat_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_sat_cnt <= '0;
        end else if (xfer && sat_hit && (o_sat_cnt != '1)) begin
            o_sat_cnt <= o_sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bound_rr_sched.sv
// Self-checking bench for bound_rr_sched: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_bound_rr_sched;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AB = 21;
    localparam int CW = 16;

    logic              clk;
    logic              rst_n;
    logic              i_relu_en;
    logic              i_cnt_clr;
    logic [N-1:0]      i_req_valid;
    logic [N*AB-1:0]   i_req_data;
    logic [N-1:0]      o_req_ready;
    logic              o_valid;
    logic              i_ready;
    logic [DW-1:0]     o_data;
    logic [1:0]        o_lane;
    logic [CW-1:0]     o_sat_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit m_valid;
    int m_ptr, m_lane, m_data, m_cnt;

    bound_rr_sched #(.N_LANE(N), .D_BW(DW), .AB_BW(AB), .CNT_BW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_relu_en(i_relu_en), .i_cnt_clr(i_cnt_clr),
        .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_lane(o_lane),
        .o_sat_cnt(o_sat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ref_bound(int x, bit relu);
        if (relu && x < 0) return 0;
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    function automatic bit ref_sat(int x, bit relu);
        return !(relu && x < 0) && (x > 127 || x < -128);
    endfunction

    function automatic logic [N-1:0] exp_ready();
        bit acc;
        acc = !m_valid || i_ready;
        if (!rst_n) return '0;
        for (int k = 0; k < N; k++) begin
            int l;
            l = (m_ptr + k) % N;
            if (i_req_valid[l]) return acc ? N'(1 << l) : '0;
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ptr = 0; m_lane = 0; m_data = 0; m_cnt = 0;
    endtask

    task automatic model_tick();
        logic [N-1:0] r;
        int g, x;
        r = exp_ready();
        if (r != '0) begin
            g = 0;
            for (int k = 0; k < N; k++) if (r[k]) g = k;
            x = $signed(i_req_data[g*AB +: AB]);
            m_valid = 1;
            m_lane  = g;
            m_data  = ref_bound(x, i_relu_en);
            m_ptr   = (g + 1) % N;
            if (ref_sat(x, i_relu_en) && m_cnt < 65535) m_cnt++;
        end else if (!m_valid || i_ready) begin
            m_valid = 0;
        end
        if (i_cnt_clr) m_cnt = 0;
    endtask

    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input int v);
        logic [AB-1:0] t;
        t = v[AB-1:0];
        i_req_data[l*AB +: AB] = t;
    endtask

    task automatic test_reset();
        rst_n = 0; i_relu_en = 0; i_cnt_clr = 0; i_ready = 0;
        i_req_valid = '1; i_req_data = '0;
        model_reset();
        #12;
        n_total++; if (o_req_ready !== 4'b0) $display("FAIL rst_ready got %b exp 0000", o_req_ready); else n_pass++;
        n_total++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", o_valid); else n_pass++;
        n_total++; if (o_data !== 8'd0 || o_lane !== 2'd0) $display("FAIL rst_data got %0d/%0d exp 0/0", o_data, o_lane); else n_pass++;
        n_total++; if (o_sat_cnt !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", o_sat_cnt); else n_pass++;
        @(posedge clk); #1; rst_n = 1;
        // Mid-stream reset with a held result and a nonzero counter
        i_req_valid = 4'b0001; set_lane(0, 500);
        cycle();
        i_req_valid = '0;
        n_total++; if (o_valid !== 1'b1 || o_sat_cnt !== 16'(m_cnt)) $display("FAIL pre_rst got v=%b cnt=%0d exp v=1 cnt=%0d", o_valid, o_sat_cnt, m_cnt); else n_pass++;
        #3 rst_n = 0;
        model_reset();
        #1;
        n_total++; if (o_valid !== 1'b0 || o_sat_cnt !== 16'd0) $display("FAIL mid_rst got v=%b cnt=%0d exp v=0 cnt=0", o_valid, o_sat_cnt); else n_pass++;
        @(posedge clk); #1; rst_n = 1;
        i_req_valid = '1; i_ready = 1;
        #1;
        n_total++; if (o_req_ready !== 4'b0001) $display("FAIL post_rst_grant got %b exp 0001", o_req_ready); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] er;
        for (int l = 0; l < N; l++) set_lane(l, 10 * l - 15);
        i_req_valid = '1; i_ready = 1;
        for (int c = 0; c < 8; c++) begin
            er = N'(1 << (c % N));
            n_total++; if (o_req_ready !== er || o_req_ready !== exp_ready()) $display("FAIL rr_ready c=%0d got %b exp %b", c, o_req_ready, er); else n_pass++;
            cycle();
            n_total++; if (o_valid !== 1'b1 || o_lane !== 2'(c % N) || $signed(o_data) !== m_data)
                $display("FAIL rr_out c=%0d got v=%b lane=%0d data=%0d exp v=1 lane=%0d data=%0d", c, o_valid, o_lane, $signed(o_data), c % N, m_data); else n_pass++;
        end
        i_req_valid = '0;
    endtask

    task automatic test_clamp();
        int vals[5] = '{300, -300, 127, -128, -5};
        int expd[5] = '{127, -128, 127, -128, -5};
        int start;
        start = m_cnt;
        i_req_valid = 4'b0100; i_relu_en = 0; i_ready = 1;
        for (int i = 0; i < 5; i++) begin
            set_lane(2, vals[i]);
            cycle();
            n_total++; if (o_lane !== 2'd2 || $signed(o_data) !== expd[i] || $signed(o_data) !== m_data)
                $display("FAIL clamp i=%0d got lane=%0d data=%0d exp lane=2 data=%0d", i, o_lane, $signed(o_data), expd[i]); else n_pass++;
        end
        n_total++; if (o_sat_cnt !== 16'(start + 2)) $display("FAIL clamp_cnt got %0d exp %0d", o_sat_cnt, start + 2); else n_pass++;
        i_req_valid = '0;
    endtask

    task automatic test_relu();
        int vals[3] = '{-5, -1000, 1000};
        int expd[3] = '{0, 0, 127};
        int ecnt[3];
        ecnt = '{m_cnt, m_cnt, m_cnt + 1};
        i_req_valid = 4'b0010; i_relu_en = 1; i_ready = 1;
        for (int i = 0; i < 3; i++) begin
            set_lane(1, vals[i]);
            cycle();
            n_total++; if (o_lane !== 2'd1 || $signed(o_data) !== expd[i] || o_sat_cnt !== 16'(ecnt[i]))
                $display("FAIL relu i=%0d got lane=%0d data=%0d cnt=%0d exp lane=1 data=%0d cnt=%0d", i, o_lane, $signed(o_data), o_sat_cnt, expd[i], ecnt[i]); else n_pass++;
        end
        i_req_valid = '0; i_relu_en = 0;
    endtask

    task automatic test_backpressure();
        i_ready = 1; i_req_valid = 4'b1000; set_lane(3, 50);
        cycle();
        i_ready = 0; i_req_valid = 4'b1001; set_lane(0, -7);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++; if (o_req_ready !== 4'b0) $display("FAIL bp_ready c=%0d got %b exp 0000", c, o_req_ready); else n_pass++;
            cycle();
            n_total++; if (o_valid !== 1'b1 || o_lane !== 2'd3 || $signed(o_data) !== 50)
                $display("FAIL bp_hold c=%0d got v=%b lane=%0d data=%0d exp v=1 lane=3 data=50", c, o_valid, o_lane, $signed(o_data)); else n_pass++;
        end
        i_ready = 1;
        #1;
        n_total++; if (o_req_ready !== 4'b0001) $display("FAIL bp_rel_ready0 got %b exp 0001", o_req_ready); else n_pass++;
        cycle();
        n_total++; if (o_lane !== 2'd0 || $signed(o_data) !== -7) $display("FAIL bp_rel_out0 got lane=%0d data=%0d exp lane=0 data=-7", o_lane, $signed(o_data)); else n_pass++;
        n_total++; if (o_req_ready !== 4'b1000) $display("FAIL bp_rel_ready3 got %b exp 1000", o_req_ready); else n_pass++;
        cycle();
        n_total++; if (o_lane !== 2'd3 || $signed(o_data) !== 50) $display("FAIL bp_rel_out3 got lane=%0d data=%0d exp lane=3 data=50", o_lane, $signed(o_data)); else n_pass++;
        i_req_valid = '0;
        cycle();
    endtask

    task automatic test_random();
        logic [N-1:0] r, er;
        r = '0;
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < N; l++) begin
                if (i_req_valid[l] && !r[l]) begin
                    if ($urandom_range(0, 7) == 0) i_req_valid[l] = 1'b0;
                end else begin
                    i_req_valid[l] = 1'($urandom_range(0, 1));
                    set_lane(l, $urandom_range(0, 800) - 400);
                end
            end
            i_ready   = ($urandom_range(0, 3) != 0);
            i_relu_en = ($urandom_range(0, 3) == 0);
            i_cnt_clr = ($urandom_range(0, 31) == 0);
            #1;
            er = exp_ready();
            n_total++; if (o_req_ready !== er) $display("FAIL rnd_ready c=%0d got %b exp %b", c, o_req_ready, er); else n_pass++;
            r = o_req_ready;
            cycle();
            n_total++; if (o_valid !== m_valid || o_lane !== 2'(m_lane) || $signed(o_data) !== m_data || o_sat_cnt !== 16'(m_cnt))
                $display("FAIL rnd_out c=%0d got v=%b lane=%0d data=%0d cnt=%0d exp v=%b lane=%0d data=%0d cnt=%0d",
                         c, o_valid, o_lane, $signed(o_data), o_sat_cnt, m_valid, m_lane, m_data, m_cnt); else n_pass++;
        end
        i_req_valid = '0; i_cnt_clr = 0; i_relu_en = 0;
    endtask

    task automatic test_sat_cnt();
        i_ready = 1; i_req_valid = '0; i_cnt_clr = 1;
        cycle();
        i_cnt_clr = 0;
        for (int l = 0; l < N; l++) set_lane(l, (l % 2 == 0) ? 1000 : -1000);
        i_req_valid = '1;
        for (int c = 0; c < 65534; c++) cycle();
        n_total++; if (o_sat_cnt !== 16'hFFFE || m_cnt != 65534) $display("FAIL cnt_preload got %h exp fffe", o_sat_cnt); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_total++; if (o_sat_cnt !== 16'hFFFF) $display("FAIL cnt_stick c=%0d got %h exp ffff", c, o_sat_cnt); else n_pass++;
        end
        i_cnt_clr = 1;
        #1;
        n_total++; if (o_req_ready === 4'b0) $display("FAIL clr_xfer_ready got %b exp nonzero", o_req_ready); else n_pass++;
        cycle();
        n_total++; if (o_sat_cnt !== 16'd0 || o_valid !== 1'b1) $display("FAIL cnt_clr_wins got cnt=%h v=%b exp cnt=0 v=1", o_sat_cnt, o_valid); else n_pass++;
        i_cnt_clr = 0; i_req_valid = '0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_clamp();
        test_relu();
        test_backpressure();
        test_random();
        test_sat_cnt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
